// File: rtl/intr_ctrl_pkg.sv
// Shared definitions for the interrupt controller: FSM encoding, register
// offsets within the bus window and the interrupt ID width.
package intr_ctrl_pkg;

  localparam int unsigned ID_W = 4;

  localparam int unsigned OFF_MASK   = 0;
  localparam int unsigned OFF_PEND   = 4;
  localparam int unsigned OFF_STATUS = 8;
  localparam int unsigned OFF_EOI    = 12;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_REQ   = 2'd1,
    ST_INSVC = 2'd2
  } state_t;

endpackage

// File: rtl/intr_prio_enc.sv
// Fixed-priority encoder: reports whether any bit is set and the index of
// the lowest set bit.
module intr_prio_enc
  import intr_ctrl_pkg::*;
#(
  parameter int unsigned NSRC = 8
) (
  input  logic [NSRC-1:0] vec,
  output logic            valid,
  output logic [ID_W-1:0] idx
);

  always_comb begin
    valid = 1'b0;
    idx   = '0;
    for (int unsigned i = 0; i < NSRC; i++) begin
      if (vec[i] && !valid) begin
        valid = 1'b1;
        idx   = ID_W'(i);
      end
    end
  end

endmodule

// File: rtl/intr_ctrl.sv
// Memory-mapped interrupt controller with MASK/PEND/STATUS/EOI registers and
// a single-level REQ/INSVC handshake. Define INTR_CTRL_EDGE_EN for
// edge-triggered pending bits; the default build latches IRQ levels.
module intr_ctrl
  import intr_ctrl_pkg::*;
#(
  parameter int unsigned      WBITS = 32,
  parameter int unsigned      NSRC  = 8,
  parameter logic [WBITS-1:0] BASE  = 32'hF0000100
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic [WBITS-1:0] ABUS,
  inout  logic [WBITS-1:0] DBUS,
  input  logic             WE,
  input  logic [NSRC-1:0]  IRQ,
  output logic             IRQ_REQ,
  input  logic             IACK,
  output logic [ID_W-1:0]  IRQ_ID
);

  state_t           state, state_nx;
  logic [NSRC-1:0]  mask, pend, eff;
  logic [ID_W-1:0]  irq_id, sel_id;
  logic             sel_valid, id_live, iack_take;
  logic             hit_mask, hit_pend, hit_status, hit_eoi;
  logic             wr_mask, wr_eoi, rd_en;
  logic [WBITS-1:0] rd_data;

  assign hit_mask   = (ABUS == BASE + WBITS'(OFF_MASK));
  assign hit_pend   = (ABUS == BASE + WBITS'(OFF_PEND));
  assign hit_status = (ABUS == BASE + WBITS'(OFF_STATUS));
  assign hit_eoi    = (ABUS == BASE + WBITS'(OFF_EOI));
  assign wr_mask    = WE && hit_mask;
  assign wr_eoi     = WE && hit_eoi;

  assign eff       = pend & mask;
  assign id_live   = |(eff & (NSRC'(1) << irq_id));
  assign iack_take = IACK && (state == ST_REQ);

  intr_prio_enc #(.NSRC(NSRC)) u_prio (
    .vec   (eff),
    .valid (sel_valid),
    .idx   (sel_id)
  );

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) mask <= '0;
    else if (wr_mask) mask <= DBUS[NSRC-1:0];
  end

`ifdef INTR_CTRL_EDGE_EN
  logic [NSRC-1:0] irq_q, pend_set, pend_clr;
  logic            wr_pend;

  assign wr_pend  = WE && hit_pend;
  assign pend_set = IRQ & ~irq_q;
  assign pend_clr = (wr_pend   ? DBUS[NSRC-1:0]          : '0)
                  | (iack_take ? (NSRC'(1) << irq_id)    : '0);

  // Set is OR-ed in after the clear so a simultaneous edge always survives.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      irq_q <= '0;
      pend  <= '0;
    end else begin
      irq_q <= IRQ;
      pend  <= (pend & ~pend_clr) | pend_set;
    end
  end
`else
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) pend <= '0;
    else       pend <= IRQ;
  end
`endif

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) state <= ST_IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      ST_IDLE:  if (sel_valid) state_nx = ST_REQ;
      ST_REQ: begin
        if (IACK)          state_nx = ST_INSVC;
        else if (!id_live) state_nx = ST_IDLE;
      end
      ST_INSVC: if (wr_eoi) state_nx = ST_IDLE;
      default:  state_nx = ST_IDLE;
    endcase
  end

  always_comb begin
    IRQ_REQ = (state == ST_REQ);
  end

  // ID is captured only on the IDLE->REQ transition and held otherwise.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) irq_id <= '0;
    else if (state == ST_IDLE && sel_valid) irq_id <= sel_id;
  end

  assign IRQ_ID = irq_id;

  always_comb begin
    rd_en   = 1'b0;
    rd_data = '0;
    if (!WE) begin
      if (hit_mask) begin
        rd_en   = 1'b1;
        rd_data = WBITS'(mask);
      end else if (hit_pend) begin
        rd_en   = 1'b1;
        rd_data = WBITS'(pend);
      end else if (hit_status) begin
        rd_en   = 1'b1;
        rd_data = WBITS'({2'(state), irq_id});
      end
    end
  end

  assign DBUS = rd_en ? rd_data : 'z;

endmodule

// File: tb/tb_intr_ctrl.sv
// Directed bench for intr_ctrl; expectations adapt to the INTR_CTRL_EDGE_EN
// build so the same bench covers both pending modes.
module tb_intr_ctrl;

  localparam logic [31:0] BASE = 32'hF0000100;
`ifdef INTR_CTRL_EDGE_EN
  localparam bit EDGE = 1'b1;
`else
  localparam bit EDGE = 1'b0;
`endif

  logic        clk, reset, we, iack, drv;
  logic [31:0] abus, wdata, rdata;
  logic [7:0]  irq;
  logic        irq_req;
  logic [3:0]  irq_id;
  tri1  [31:0] dbus;

  int unsigned n_chk = 0;
  int unsigned n_bad = 0;

  assign dbus = drv ? wdata : 'z;

  intr_ctrl #(.WBITS(32), .NSRC(8), .BASE(BASE)) dut (
    .CLK     (clk),
    .RESET   (reset),
    .ABUS    (abus),
    .DBUS    (dbus),
    .WE      (we),
    .IRQ     (irq),
    .IRQ_REQ (irq_req),
    .IACK    (iack),
    .IRQ_ID  (irq_id)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [31:0] off, input logic [31:0] data);
    abus = BASE + off; wdata = data; drv = 1'b1; we = 1'b1;
    tick();
    we = 1'b0; drv = 1'b0; abus = '0;
  endtask

  task automatic rd(input logic [31:0] off, output logic [31:0] data);
    abus = BASE + off; we = 1'b0;
    #1;
    data = dbus;
    abus = '0;
  endtask

  task automatic do_reset();
    reset = 1'b1; irq = '0; iack = 1'b0; we = 1'b0; drv = 1'b0; abus = '0;
    tick(); tick();
    reset = 1'b0;
  endtask

  initial begin
    wdata = '0;
    do_reset();

    // reset state
    chk("rst_req", 32'(irq_req), 32'd0);
    chk("rst_id", 32'(irq_id), 32'd0);
    rd(0, rdata); chk("rst_mask", rdata, 32'h0);
    rd(4, rdata); chk("rst_pend", rdata, 32'h0);
    rd(8, rdata); chk("rst_status", rdata, 32'h0);

    // single source latency
    wr(0, 32'h04);
    irq = 8'h04;
    tick();
    chk("lat_req_k", 32'(irq_req), 32'd0);
    rd(4, rdata); chk("lat_pend_k", rdata, 32'h04);
    tick();
    chk("lat_req_k1", 32'(irq_req), 32'd1);
    chk("lat_id", 32'(irq_id), 32'd2);
    rd(8, rdata); chk("lat_status", rdata, 32'h12);

    // priority, IACK, EOI, next request
    do_reset();
    wr(0, 32'hFF);
    irq = 8'h22;
    tick(); tick();
    chk("pri_req", 32'(irq_req), 32'd1);
    chk("pri_id1", 32'(irq_id), 32'd1);
    iack = 1'b1; tick(); iack = 1'b0;
    chk("pri_insvc_req", 32'(irq_req), 32'd0);
    rd(8, rdata); chk("pri_insvc_st", rdata, 32'h21);
    rd(4, rdata); chk("pri_pend_iack", rdata, EDGE ? 32'h20 : 32'h22);
    irq = 8'h20;
    wr(12, 32'h0);
    rd(8, rdata); chk("pri_eoi_st", rdata, 32'h01);
    tick();
    chk("pri_req5", 32'(irq_req), 32'd1);
    rd(8, rdata); chk("pri_st5", rdata, 32'h15);

    // withdrawal by masking, stray IACK
    do_reset();
    wr(0, 32'h04);
    irq = 8'h04;
    tick(); tick();
    wr(0, 32'h00);
    chk("wd_req_hold", 32'(irq_req), 32'd1);
    tick();
    chk("wd_req_drop", 32'(irq_req), 32'd0);
    rd(8, rdata); chk("wd_st_idle", rdata, 32'h02);
    iack = 1'b1; tick(); iack = 1'b0;
    rd(8, rdata); chk("wd_iack_ign", rdata, 32'h02);
    rd(4, rdata); chk("wd_pend_keep", rdata, 32'h04);

    // PEND writes vs. set events
    do_reset();
    irq = 8'h08; tick();
    rd(4, rdata); chk("pw_set", rdata, 32'h08);
    irq = 8'h00; tick();
    irq = 8'h08;
    wr(4, 32'h08);
    rd(4, rdata); chk("pw_set_wins", rdata, 32'h08);
    wr(4, 32'h08);
    rd(4, rdata); chk("pw_w1c", rdata, EDGE ? 32'h00 : 32'h08);

    // held level source: re-request after EOI, then reset in INSVC
    do_reset();
    wr(0, 32'h01);
    irq = 8'h01;
    tick(); tick();
    chk("lv_req", 32'(irq_req), 32'd1);
    iack = 1'b1; tick(); iack = 1'b0;
    rd(8, rdata); chk("lv_insvc", rdata, 32'h20);
    wr(12, 32'h0);
    rd(8, rdata); chk("lv_eoi", rdata, 32'h00);
    tick();
    chk("lv_rereq", 32'(irq_req), EDGE ? 32'd0 : 32'd1);
    chk("lv_rereq_id", 32'(irq_id), 32'd0);
    irq = 8'h00; tick(); tick();
    irq = 8'h01; tick(); tick();
    iack = 1'b1; tick(); iack = 1'b0;
    rd(8, rdata); chk("rs_insvc", rdata, 32'h20);
    reset = 1'b1;
    #2;
    chk("rs_req", 32'(irq_req), 32'd0);
    rd(0, rdata); chk("rs_mask", rdata, 32'h0);
    rd(8, rdata); chk("rs_status", rdata, 32'h0);
    reset = 1'b0;
    tick();

    // bus decode and tri-state release
    wr(0, 32'h5A);
    rd(0, rdata); chk("bus_zext", rdata, 32'h0000005A);
    rd(16, rdata); chk("bus_unmapped", rdata, 32'hFFFFFFFF);
    rd(12, rdata); chk("bus_eoi_wo", rdata, 32'hFFFFFFFF);
    abus = BASE; we = 1'b1; #1;
    chk("bus_we_rd", dbus, 32'hFFFFFFFF);
    we = 1'b0; abus = '0;

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule

// File: doc/intr_ctrl.md
INTR_CTRL -- requirements
Module: intr_ctrl

Interface
REQ-001 The block SHALL have parameter WBITS, default 32, meaning the bus address/data width.
REQ-002 The block SHALL have parameter NSRC, default 8 (range 1..16), meaning the number of interrupt sources.
REQ-003 The block SHALL have parameter BASE, default 32'hF0000100, meaning the base address of the register window.
REQ-004 The block SHALL have port CLK, input, 1, the system clock; all state changes on its rising edge.
REQ-005 The block SHALL have port RESET, input, 1, asynchronous active-high reset.
REQ-006 The block SHALL have port ABUS, input, WBITS, the bus address.
REQ-007 The block SHALL have port DBUS, inout, WBITS, the shared data bus.
REQ-008 The block SHALL have port WE, input, 1, the bus write strobe.
REQ-009 The block SHALL have port IRQ, input, NSRC, the device interrupt lines (each device's INTR output), active-high.
REQ-010 The block SHALL have port IRQ_REQ, output, 1, the interrupt request to the CPU.
REQ-011 The block SHALL have port IACK, input, 1, the CPU interrupt acknowledge, a one-cycle pulse.
REQ-012 The block SHALL have port IRQ_ID, output, 4, the index of the source being requested or serviced.

Function
REQ-013 Register map SHALL be: BASE+0 MASK (RW, NSRC bits); BASE+4 PEND (R; write-1-to-clear in edge mode); BASE+8 STATUS (R, {state[1:0], IRQ_ID[3:0]} in bits [5:0]); BASE+12 EOI (W, any data).
REQ-014 DBUS SHALL be driven, zero-extended, only when !WE and ABUS matches a readable address; otherwise it SHALL be all-Z.
REQ-015 The effective pending vector SHALL be PEND & MASK; the selected ID SHALL be the lowest set index.
REQ-016 The FSM SHALL have states IDLE=0, REQ=1, INSVC=2.
REQ-017 In IDLE, if the effective pending vector is nonzero, the block SHALL register the selected ID into IRQ_ID and go to REQ on the same edge.
REQ-018 In REQ, IRQ_REQ SHALL be 1. IACK SHALL move the FSM to INSVC; in edge mode it SHALL also clear PEND[IRQ_ID].
REQ-019 In REQ without IACK, if bit IRQ_ID of the effective pending vector is 0 (masked or withdrawn), the FSM SHALL return to IDLE with IRQ_REQ low; IRQ_ID SHALL NOT be re-selected while in REQ.
REQ-020 In INSVC, IRQ_REQ SHALL be 0 and IRQ_ID SHALL hold; an EOI write SHALL return the FSM to IDLE. Nesting/preemption SHALL NOT occur.
REQ-021 Latency: with IRQ[i] rising before edge k, PEND[i] SHALL be set at edge k and IRQ_REQ SHALL be high after edge k+1.
REQ-022 IACK outside REQ and EOI outside INSVC SHALL be ignored.
REQ-023 A set event for a PEND bit SHALL win over a W1C or IACK clear of that bit in the same cycle.
REQ-024 IRQ_ID SHALL be driven only from a register and SHALL retain its value outside REQ/INSVC.

Reset
REQ-025 RESET SHALL force state IDLE, MASK=0, PEND=0, IRQ_ID=0, IRQ_REQ=0 and the edge history register to 0; RESET mid-REQ or mid-INSVC SHALL abandon the transaction without requiring an EOI.

Configuration
REQ-026 With INTR_CTRL_EDGE_EN defined, PEND[i] SHALL set on a rising edge of registered IRQ[i] and SHALL clear only via IACK or W1C, and PEND writes SHALL be accepted.
REQ-027 Without INTR_CTRL_EDGE_EN, PEND SHALL equal registered IRQ (level mode), PEND writes SHALL be ignored, and IACK SHALL not alter PEND.

Structure
REQ-028 Package intr_ctrl_pkg SHALL hold the state encoding, the register offsets (0/4/8/12) and the ID width constant 4.
REQ-029 The lowest-index priority selection SHALL be a sub-module intr_prio_enc (NSRC-bit vector in; valid and 4-bit index out).

Verification
REQ-030 Reset then MASK=8'h04, IRQ[2] pulse -> IRQ_REQ=1 two edges later, IRQ_ID=2, STATUS=6'h12.
REQ-031 IRQ[5] and IRQ[1] rise together, MASK=8'hFF -> ID=1 first; IACK plus EOI -> next request ID=5.
REQ-032 In REQ, write MASK=0 -> IRQ_REQ drops next edge and FSM returns to IDLE; IACK issued afterwards has no effect.
REQ-033 Edge mode: IRQ[3] edge in the same cycle as a W1C of PEND=8'h08 -> PEND[3] stays 1.
REQ-034 Level mode: IRQ[0] held high, IACK then EOI -> immediate re-request with ID=0; RESET asserted in INSVC -> IDLE with IRQ_REQ=0 and MASK=0.
REQ-035 Read of BASE+16 or a read with WE=1 -> DBUS stays all-Z.
